// File: rtl/fetcher_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Holds the RISC-V instruction exception cause codes and the fetcher FSM
// state encoding. The decoder and exception unit use the same cause codes.
package fetcher_pkg;

    localparam logic [3:0] CAUSE_INSTR_MISALIGNED   = 4'd0;
    localparam logic [3:0] CAUSE_INSTR_ACCESS_FAULT = 4'd1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetcher.sv
// Instruction-fetch stage of the multi-cycle RV32 core.
// Reads one 32-bit word at the requested PC over the instruction bus and
// hands it to the decoder with a one-cycle completed pulse. A misaligned PC
// or a bus fault is reported as an exception instead of an instruction.
//
// Ports:
//   clk, rstn          clock, synchronous active-low reset
//   enabled, pc        start request and fetch address (sampled in IDLE)
//   flush              abandon the fetch in flight
//   completed          one-cycle pulse, result outputs valid
//   instr_raw, pc_out  fetched word and its PC (held)
//   exception, cause   fetch failed and why (held)
//   tval               faulting PC (held)
//   mem_request/addr   bus request (level) and word address
//   mem_ready/rdata    bus completion and read data
//   mem_fault          bus error, qualified by mem_ready
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no bus access; waiting for enabled
// ST_WAIT  | request on the bus, result will be delivered
// ST_DRAIN | flushed; request kept up until the bus finishes, result dropped
module fetcher
    import fetcher_pkg::*;
#(
    parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enabled,
    input  logic        flush,
    input  logic [31:0] pc,
    output logic        completed,
    output logic [31:0] instr_raw,
    output logic [31:0] pc_out,
    output logic        exception,
    output logic [3:0]  cause,
    output logic [31:0] tval,
    output logic        mem_request,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    input  logic        mem_fault
);

    fetch_state_e state_q, state_d;
    logic         completed_q, completed_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc_out_q, pc_out_d;
    logic         exc_q, exc_d;
    logic [3:0]   cause_q, cause_d;
    logic [31:0]  tval_q, tval_d;
    logic         req_q, req_d;
    logic [31:0]  addr_q, addr_d;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            completed_q <= 1'b0;
            instr_q     <= RESET_INSTR;
            pc_out_q    <= '0;
            exc_q       <= 1'b0;
            cause_q     <= '0;
            tval_q      <= '0;
            req_q       <= 1'b0;
            addr_q      <= '0;
        end else begin
            state_q     <= state_d;
            completed_q <= completed_d;
            instr_q     <= instr_d;
            pc_out_q    <= pc_out_d;
            exc_q       <= exc_d;
            cause_q     <= cause_d;
            tval_q      <= tval_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        completed_d = 1'b0;
        instr_d     = instr_q;
        pc_out_d    = pc_out_q;
        exc_d       = exc_q;
        cause_d     = cause_q;
        tval_d      = tval_q;
        req_d       = req_q;
        addr_d      = addr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (enabled) begin
                    if (pc[1:0] == 2'b00) begin
                        addr_d  = pc;
                        req_d   = 1'b1;
                        state_d = ST_WAIT;
                    end else begin
                        // Misaligned: report immediately, never touch the bus.
                        completed_d = 1'b1;
                        exc_d       = 1'b1;
                        cause_d     = CAUSE_INSTR_MISALIGNED;
                        tval_d      = pc;
                        instr_d     = RESET_INSTR;
                        pc_out_d    = pc;
                    end
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    // Flush beats a simultaneous mem_ready; otherwise the
                    // transaction must still be allowed to finish.
                    if (mem_ready) begin
                        req_d   = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else if (mem_ready) begin
                    req_d       = 1'b0;
                    state_d     = ST_IDLE;
                    completed_d = 1'b1;
                    pc_out_d    = addr_q;
                    if (mem_fault) begin
                        exc_d   = 1'b1;
                        cause_d = CAUSE_INSTR_ACCESS_FAULT;
                        tval_d  = addr_q;
                        instr_d = RESET_INSTR;
                    end else begin
                        exc_d   = 1'b0;
                        instr_d = mem_rdata;
                    end
                end
            end
            ST_DRAIN: begin
                if (mem_ready) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign completed   = completed_q;
    assign instr_raw   = instr_q;
    assign pc_out      = pc_out_q;
    assign exception   = exc_q;
    assign cause       = cause_q;
    assign tval        = tval_q;
    assign mem_request = req_q;
    assign mem_addr    = addr_q;

endmodule

// File: tb/tb_fetcher.sv
module tb_fetcher;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enabled = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] pc = '0;
    logic        completed;
    logic [31:0] instr_raw;
    logic [31:0] pc_out;
    logic        exception;
    logic [3:0]  cause;
    logic [31:0] tval;
    logic        mem_request;
    logic [31:0] mem_addr;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_fault = 1'b0;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    fetcher dut (
        .clk        (clk),
        .rstn       (rstn),
        .enabled    (enabled),
        .flush      (flush),
        .pc         (pc),
        .completed  (completed),
        .instr_raw  (instr_raw),
        .pc_out     (pc_out),
        .exception  (exception),
        .cause      (cause),
        .tval       (tval),
        .mem_request(mem_request),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .mem_fault  (mem_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Transaction-level reference: one outstanding bus read at most; a flush
    // marks it as discarded; a completion is produced for a non-discarded
    // read when the bus answers, or immediately for a misaligned address.
    bit          m_busy = 1'b0;
    bit          m_discard = 1'b0;
    logic        e_completed = 1'b0;
    logic [31:0] e_instr = NOP;
    logic [31:0] e_pc_out = '0;
    logic        e_exc = 1'b0;
    logic [3:0]  e_cause = '0;
    logic [31:0] e_tval = '0;
    logic        e_req = 1'b0;
    logic [31:0] e_addr = '0;

    always @(posedge clk) begin
        e_completed = 1'b0;
        if (!rstn) begin
            m_busy = 0; m_discard = 0;
            e_instr = NOP; e_pc_out = 0; e_exc = 0; e_cause = 0;
            e_tval = 0; e_req = 0; e_addr = 0;
        end else if (m_busy) begin
            if (flush) m_discard = 1;
            if (mem_ready) begin
                m_busy = 0;
                e_req = 0;
                if (!m_discard) begin
                    e_completed = 1;
                    e_pc_out = e_addr;
                    if (mem_fault) begin
                        e_exc = 1; e_cause = 1; e_tval = e_addr; e_instr = NOP;
                    end else begin
                        e_exc = 0; e_instr = mem_rdata;
                    end
                end
                m_discard = 0;
            end
        end else if (enabled) begin
            if (pc % 4 == 0) begin
                m_busy = 1; e_req = 1; e_addr = pc;
            end else begin
                e_completed = 1; e_exc = 1; e_cause = 0; e_tval = pc;
                e_instr = NOP; e_pc_out = pc;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("completed",   {31'b0, completed},   {31'b0, e_completed});
            chk("mem_request", {31'b0, mem_request}, {31'b0, e_req});
            chk("mem_addr",    mem_addr,  e_addr);
            chk("instr_raw",   instr_raw, e_instr);
            chk("pc_out",      pc_out,    e_pc_out);
            chk("exception",   {31'b0, exception}, {31'b0, e_exc});
            chk("cause",       {28'b0, cause},     {28'b0, e_cause});
            chk("tval",        tval,      e_tval);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst instr_raw", instr_raw, NOP);
        chk("rst completed", {31'b0, completed}, 32'd0);
        chk("rst mem_request", {31'b0, mem_request}, 32'd0);
        rstn = 1'b1;
        tick();

        // zero-wait fetch at 0x100
        enabled = 1; pc = 32'h100;
        tick();
        enabled = 0;
        chk("zw req", {31'b0, mem_request}, 32'd1);
        chk("zw addr", mem_addr, 32'h100);
        mem_ready = 1; mem_rdata = 32'h00A0_0093;
        tick();
        mem_ready = 0; mem_rdata = 0;
        chk("zw completed", {31'b0, completed}, 32'd1);
        chk("zw instr", instr_raw, 32'h00A0_0093);
        chk("zw pc_out", pc_out, 32'h100);
        chk("zw exception", {31'b0, exception}, 32'd0);
        chk("zw req drop", {31'b0, mem_request}, 32'd0);
        tick();

        // 3 wait states at 0x200
        enabled = 1; pc = 32'h200;
        tick();
        enabled = 0;
        ticks(3);
        mem_ready = 1; mem_rdata = 32'h0040_0113;
        tick();
        mem_ready = 0;
        chk("ws instr", instr_raw, 32'h0040_0113);
        tick();
        chk("ws single pulse", {31'b0, completed}, 32'd0);

        // misaligned, followed by a fetch accepted in the completed cycle
        enabled = 1; pc = 32'h102;
        tick();
        chk("mis completed", {31'b0, completed}, 32'd1);
        chk("mis exception", {31'b0, exception}, 32'd1);
        chk("mis tval", tval, 32'h102);
        chk("mis instr", instr_raw, NOP);
        chk("mis req", {31'b0, mem_request}, 32'd0);
        pc = 32'h104;
        tick();
        enabled = 0;
        mem_ready = 1; mem_rdata = 32'h1234_5678;
        tick();
        mem_ready = 0;
        tick();

        // bus fault at 0x300
        enabled = 1; pc = 32'h300;
        tick();
        enabled = 0;
        tick();
        mem_ready = 1; mem_fault = 1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ready = 0; mem_fault = 0;
        chk("flt cause", {28'b0, cause}, 32'd1);
        chk("flt tval", tval, 32'h300);
        chk("flt instr", instr_raw, NOP);
        tick();

        // flush one cycle after request, bus answers two cycles later
        enabled = 1; pc = 32'h500;
        tick();
        enabled = 0; flush = 1;
        tick();
        flush = 0;
        enabled = 1; pc = 32'h900;
        tick();
        enabled = 0;
        mem_ready = 1; mem_rdata = 32'hAAAA_AAAA;
        chk("drain req held", {31'b0, mem_request}, 32'd1);
        tick();
        mem_ready = 0;
        chk("drain no completed", {31'b0, completed}, 32'd0);
        chk("drain pc_out kept", pc_out, 32'h300);
        tick();
        enabled = 1; pc = 32'h400;
        tick();
        enabled = 0;
        ticks(1);
        mem_ready = 1; mem_rdata = 32'h0000_0513;
        tick();
        mem_ready = 0;
        chk("after flush pc_out", pc_out, 32'h400);
        tick();

        // enabled during WAIT, then flush with mem_ready in the same cycle
        enabled = 1; pc = 32'h600;
        tick();
        pc = 32'h700;
        tick();
        enabled = 0;
        flush = 1; mem_ready = 1; mem_rdata = 32'hBBBB_BBBB;
        tick();
        flush = 0; mem_ready = 0;
        chk("flush+ready no completed", {31'b0, completed}, 32'd0);
        ticks(3);

        // flush in IDLE is a no-op
        flush = 1;
        tick();
        flush = 0;
        tick();

        // reset during WAIT drops the request
        enabled = 1; pc = 32'h800;
        tick();
        enabled = 0;
        rstn = 0;
        tick();
        chk("rst mid wait req", {31'b0, mem_request}, 32'd0);
        rstn = 1;
        ticks(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
